// File: rtl/axi4lite_read_ctrl.sv
// rtl/axi4lite_read_ctrl.sv - AXI4-Lite read slave decoding araddr into backend region requests
// Optional one-entry address buffer when AXIL_RD_ADDR_BUF_EN is defined.
module axi4lite_read_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pNUM_REGION = 4,
    parameter int pREGION_LSB = 8,
    parameter int pTIMEOUT    = 16
) (
    input  logic                             axis_clk,
    input  logic                             axis_rst,
    input  logic [pADDR_WIDTH-1:0]           araddr,
    input  logic                             arvalid,
    output logic                             arready,
    output logic [pDATA_WIDTH-1:0]           rdata,
    output logic [1:0]                       rresp,
    output logic                             rvalid,
    input  logic                             rready,
    output logic [pNUM_REGION-1:0]           rd_req,
    output logic [pADDR_WIDTH-1:0]           rd_addr,
    input  logic [pNUM_REGION*pDATA_WIDTH-1:0] rd_data,
    input  logic [pNUM_REGION-1:0]           rd_ack,
    output logic [1:0]                       state_o
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         TW          = $clog2(pTIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(pTIMEOUT - 1);
    localparam logic [4:0] NUM_REGION  = 5'(pNUM_REGION);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state_q;
    logic [TW-1:0]            timer_q;
    logic                     ar_hs;
    logic                     r_hs;
    logic                     ack_hit;
    logic [pDATA_WIDTH-1:0]   ack_data;
    logic                     launch;
    logic [pADDR_WIDTH-1:0]   launch_addr;
    logic [3:0]               launch_region;
    logic                     launch_mapped;
    logic [pNUM_REGION-1:0]   launch_onehot;

`ifdef AXIL_RD_ADDR_BUF_EN
    logic                     buf_valid_q;
    logic [pADDR_WIDTH-1:0]   buf_addr_q;
`endif

    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign state_o = state_q;

    // rd_req is the one-hot of the selected region, so it doubles as the ack/data select
    assign ack_hit = (state_q == BUSY) && |(rd_ack & rd_req);

    always_comb begin
        ack_data = '0;
        for (int i = 0; i < pNUM_REGION; i++) begin
            if (rd_req[i]) ack_data = rd_data[i*pDATA_WIDTH +: pDATA_WIDTH];
        end
    end

    always_comb begin
        launch      = 1'b0;
        launch_addr = araddr;
        if (state_q == IDLE) begin
            launch = ar_hs;
        end
`ifdef AXIL_RD_ADDR_BUF_EN
        else if (state_q == RESP && r_hs) begin
            launch = buf_valid_q || ar_hs;
            if (buf_valid_q) launch_addr = buf_addr_q;
        end
`endif
    end

    assign launch_region = launch_addr[pREGION_LSB+3 -: 4];
    assign launch_mapped = {1'b0, launch_region} < NUM_REGION;

    always_comb begin
        launch_onehot = '0;
        for (int i = 0; i < pNUM_REGION; i++) begin
            launch_onehot[i] = (launch_region == 4'(i));
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q <= IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
            rd_req  <= '0;
            rd_addr <= '0;
            timer_q <= '0;
`ifdef AXIL_RD_ADDR_BUF_EN
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
`endif
        end else begin
`ifdef AXIL_RD_ADDR_BUF_EN
            if (ar_hs && state_q != IDLE && !launch) begin
                buf_valid_q <= 1'b1;
                buf_addr_q  <= araddr;
                arready     <= 1'b0;
            end
`endif
            case (state_q)
                BUSY: begin
                    if (ack_hit) begin
                        rd_req  <= '0;
                        rvalid  <= 1'b1;
                        rdata   <= ack_data;
                        rresp   <= RESP_OKAY;
                        state_q <= RESP;
                    end else if (timer_q == TIMER_LAST) begin
                        rd_req  <= '0;
                        rvalid  <= 1'b1;
                        rdata   <= '0;
                        rresp   <= RESP_SLVERR;
                        state_q <= RESP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RESP: begin
                    if (r_hs) begin
                        rvalid  <= 1'b0;
                        state_q <= IDLE;
                        arready <= 1'b1;
                    end
                end
                default: ;
            endcase
            // A new read overrides the defaults above, whether from IDLE or a drained buffer
            if (launch) begin
                rd_addr <= launch_addr;
                timer_q <= '0;
`ifdef AXIL_RD_ADDR_BUF_EN
                buf_valid_q <= 1'b0;
                arready     <= 1'b1;
`else
                arready     <= 1'b0;
`endif
                if (launch_mapped) begin
                    state_q <= BUSY;
                    rd_req  <= launch_onehot;
                    rvalid  <= 1'b0;
                end else begin
                    state_q <= RESP;
                    rd_req  <= '0;
                    rvalid  <= 1'b1;
                    rdata   <= '0;
                    rresp   <= RESP_SLVERR;
                end
            end
        end
    end
endmodule
